// File: rtl/vit_pkg.sv
// Shared ViT fixed-point package: Q-format constants, saturating round helpers, patch_embed state type.
// Helpers operate on a 64-bit signed intermediate so any accumulator up to that width fits.
package vit_pkg;

   localparam int Q_FRAC = 8;
   localparam logic signed [15:0] Q_ONE = 16'sh0100;

   typedef enum logic [2:0] {S_IDLE, S_CLS, S_MAC, S_WRITE, S_DONE} pe_state_t;

   // Counter width helper that never collapses to zero bits.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [63:0] sat_val(input logic signed [63:0] v, input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Round half up, arithmetic shift, then clamp to a dw-bit signed word.
   function automatic logic signed [63:0] sat_round(input logic signed [63:0] v, input int frac,
                                                    input int dw);
      return sat_val((v + (64'sd1 <<< (frac - 1))) >>> frac, dw);
   endfunction

endpackage

// File: rtl/fxp_mac.sv
// Registered signed multiply-accumulate: acc += a*b when en, cleared by clr (clr wins).
// Latency 1 cycle per MAC; no backpressure, caller sequences en/clr.
module fxp_mac #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_W      = 38
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [ACC_W-1:0]      acc
);

   logic signed [2*DATA_WIDTH-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc + ACC_W'(prod);
   end

endmodule

// File: rtl/patch_embed.sv
// Patch embedding: PATCHxPATCH patches projected to EMB_DIM plus bias and positional embedding;
// optional CLS token under PATCH_EMBED_CLS_EN. Latency NUM_PATCHES*EMB_DIM*(PATCH_PIX+1)+1 (+EMB_DIM with CLS).
// No backpressure: start taken only in S_IDLE, done/out_valid pulse once per run.
module patch_embed
   import vit_pkg::*;
#(
   parameter int  DATA_WIDTH  = 16,
   parameter int  FRAC_BITS   = Q_FRAC,
   parameter int  IMG_H       = 8,
   parameter int  IMG_W       = 16,
   parameter int  PATCH       = 4,
   parameter int  EMB_DIM     = 8,
   localparam int NUM_PATCHES = (IMG_H / PATCH) * (IMG_W / PATCH),
`ifdef PATCH_EMBED_CLS_EN
   localparam int SEQ_LEN     = NUM_PATCHES + 1,
`else
   localparam int SEQ_LEN     = NUM_PATCHES,
`endif
   localparam int PATCH_PIX   = PATCH * PATCH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         done,
   output logic                         out_valid,
   input  logic signed [DATA_WIDTH-1:0] img_in [IMG_H*IMG_W],
   input  logic signed [DATA_WIDTH-1:0] W_pe   [PATCH_PIX*EMB_DIM],
   input  logic signed [DATA_WIDTH-1:0] b_pe   [EMB_DIM],
   input  logic signed [DATA_WIDTH-1:0] pos_in [SEQ_LEN*EMB_DIM],
`ifdef PATCH_EMBED_CLS_EN
   input  logic signed [DATA_WIDTH-1:0] cls_in [EMB_DIM],
`endif
   output logic signed [DATA_WIDTH-1:0] x_out  [SEQ_LEN*EMB_DIM]
);

   localparam int NPH    = IMG_H / PATCH;
   localparam int NPW    = IMG_W / PATCH;
   localparam int ACC_W  = 2*DATA_WIDTH + $clog2(PATCH_PIX) + 2;
   localparam int PR_W   = cw(NPH);
   localparam int PC_W   = cw(NPW);
   localparam int KP_W   = cw(PATCH);
   localparam int K_W    = cw(PATCH_PIX);
   localparam int E_W    = cw(EMB_DIM);
   localparam int T_W    = cw(SEQ_LEN + 1);
   localparam int IMG_AW = cw(IMG_H*IMG_W);
   localparam int W_AW   = cw(PATCH_PIX*EMB_DIM);
   localparam int X_AW   = cw(SEQ_LEN*EMB_DIM);

   localparam logic [PR_W-1:0] PR_LAST = PR_W'(NPH - 1);
   localparam logic [PC_W-1:0] PC_LAST = PC_W'(NPW - 1);
   localparam logic [KP_W-1:0] KP_LAST = KP_W'(PATCH - 1);
   localparam logic [K_W-1:0]  K_LAST  = K_W'(PATCH_PIX - 1);
   localparam logic [E_W-1:0]  E_LAST  = E_W'(EMB_DIM - 1);

   pe_state_t                state;
   logic [PR_W-1:0]          pr;
   logic [PC_W-1:0]          pc;
   logic [KP_W-1:0]          kr, kc;
   logic [K_W-1:0]           k;
   logic [E_W-1:0]           e;
   logic [T_W-1:0]           tok;
   logic [IMG_AW-1:0]        pix_idx;
   logic [W_AW-1:0]          w_idx;
   logic [X_AW-1:0]          x_idx;
   logic signed [ACC_W-1:0]  acc;
   logic signed [63:0]       sum;
   logic signed [DATA_WIDTH-1:0] res;

   // Pixel address built from nested patch/in-patch counters, so no division is needed.
   always_comb begin
      pix_idx = IMG_AW'((int'(pr)*PATCH + int'(kr))*IMG_W + int'(pc)*PATCH + int'(kc));
      w_idx   = W_AW'(int'(k)*EMB_DIM + int'(e));
      x_idx   = X_AW'(int'(tok)*EMB_DIM + int'(e));
      sum     = 64'(acc) + (64'(b_pe[e]) <<< FRAC_BITS) + (64'(pos_in[x_idx]) <<< FRAC_BITS);
      res     = DATA_WIDTH'(sat_round(sum, FRAC_BITS, DATA_WIDTH));
   end

   fxp_mac #(.DATA_WIDTH(DATA_WIDTH), .ACC_W(ACC_W)) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   ((state == S_IDLE) || (state == S_WRITE)),
      .en    (state == S_MAC),
      .a     (img_in[pix_idx]),
      .b     (W_pe[w_idx]),
      .acc   (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         done      <= 1'b0;
         out_valid <= 1'b0;
         pr        <= '0;
         pc        <= '0;
         kr        <= '0;
         kc        <= '0;
         k         <= '0;
         e         <= '0;
         tok       <= '0;
         for (int i = 0; i < SEQ_LEN*EMB_DIM; i++) x_out[i] <= '0;
      end else begin
         done      <= 1'b0;
         out_valid <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               pr  <= '0;
               pc  <= '0;
               kr  <= '0;
               kc  <= '0;
               k   <= '0;
               e   <= '0;
               tok <= '0;
`ifdef PATCH_EMBED_CLS_EN
               state <= S_CLS;
`else
               state <= S_MAC;
`endif
            end
`ifdef PATCH_EMBED_CLS_EN
            S_CLS: begin
               x_out[x_idx] <= DATA_WIDTH'(sat_val(64'(cls_in[e]) + 64'(pos_in[x_idx]), DATA_WIDTH));
               if (e == E_LAST) begin
                  e     <= '0;
                  tok   <= T_W'(1);
                  state <= S_MAC;
               end else begin
                  e <= e + 1'b1;
               end
            end
`endif
            S_MAC: begin
               if (kc == KP_LAST) begin
                  kc <= '0;
                  kr <= (kr == KP_LAST) ? '0 : kr + 1'b1;
               end else begin
                  kc <= kc + 1'b1;
               end
               if (k == K_LAST) begin
                  k     <= '0;
                  state <= S_WRITE;
               end else begin
                  k <= k + 1'b1;
               end
            end
            S_WRITE: begin
               x_out[x_idx] <= res;
               state        <= S_MAC;
               if (e == E_LAST) begin
                  e   <= '0;
                  tok <= tok + 1'b1;
                  if (pc == PC_LAST) begin
                     pc <= '0;
                     if (pr == PR_LAST) begin
                        pr    <= '0;
                        state <= S_DONE;
                     end else begin
                        pr <= pr + 1'b1;
                     end
                  end else begin
                     pc <= pc + 1'b1;
                  end
               end else begin
                  e <= e + 1'b1;
               end
            end
            S_DONE: begin
               done      <= 1'b1;
               out_valid <= 1'b1;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_patch_embed.sv
// Scoreboard bench for patch_embed: expected tokens come from a plain-arithmetic model,
// a monitor compares them (and start-to-done latency) whenever done is presented.
module tb_patch_embed;

   localparam int IMG_H = 8, IMG_W = 16, PATCH = 4, EMB_DIM = 8;
   localparam int NPW = IMG_W / PATCH;
   localparam int NUM_P = (IMG_H / PATCH) * NPW;
   localparam int PP = PATCH * PATCH;
`ifdef PATCH_EMBED_CLS_EN
   localparam int CLS_OFF = 1;
`else
   localparam int CLS_OFF = 0;
`endif
   localparam int SEQ = NUM_P + CLS_OFF;
   localparam int NX = SEQ * EMB_DIM;
   localparam int LAT = CLS_OFF*EMB_DIM + NUM_P*EMB_DIM*(PP+1) + 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic done, out_valid;
   logic signed [15:0] img [IMG_H*IMG_W];
   logic signed [15:0] w   [PP*EMB_DIM];
   logic signed [15:0] b   [EMB_DIM];
   logic signed [15:0] pos [NX];
   logic signed [15:0] cls [EMB_DIM];
   logic signed [15:0] x_out [NX];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int runs_seen = 0;
   int done_cnt = 0;
   int exp_q[$];
   int start_q[$];

   patch_embed dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .done      (done),
      .out_valid (out_valid),
      .img_in    (img),
      .W_pe      (w),
      .b_pe      (b),
      .pos_in    (pos),
`ifdef PATCH_EMBED_CLS_EN
      .cls_in    (cls),
`endif
      .x_out     (x_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic logic signed [15:0] rnd(input int mag);
      if (mag == 0) return 16'($urandom());
      return 16'(int'($urandom_range(0, 2*mag)) - mag);
   endfunction

   // Reference: token t takes patch p = t - CLS_OFF, pixels located by division/modulo.
   task automatic push_expected();
      longint acc, v;
      int p, pr, pc, row, col;
      for (int t = 0; t < SEQ; t++) begin
         for (int e = 0; e < EMB_DIM; e++) begin
            if (CLS_OFF == 1 && t == 0) begin
               v = clamp16(longint'(cls[e]) + longint'(pos[e]));
            end else begin
               p = t - CLS_OFF;
               pr = p / NPW;
               pc = p % NPW;
               acc = 0;
               for (int k = 0; k < PP; k++) begin
                  row = pr*PATCH + k/PATCH;
                  col = pc*PATCH + k%PATCH;
                  acc += longint'(img[row*IMG_W + col]) * longint'(w[k*EMB_DIM + e]);
               end
               v = acc + longint'(b[e])*256 + longint'(pos[t*EMB_DIM + e])*256 + 128;
               v = clamp16(v >>> 8);
            end
            exp_q.push_back(int'(v));
         end
      end
   endtask

   task automatic set_inputs(input int mode);
      for (int i = 0; i < IMG_H*IMG_W; i++) img[i] = '0;
      for (int i = 0; i < PP*EMB_DIM; i++) w[i] = '0;
      for (int i = 0; i < EMB_DIM; i++) begin b[i] = '0; cls[i] = '0; end
      for (int i = 0; i < NX; i++) pos[i] = '0;
      case (mode)
         0: begin
            for (int i = 0; i < IMG_H*IMG_W; i++) img[i] = 16'sh0100;
            for (int i = 0; i < PP*EMB_DIM; i++) w[i] = 16'sh0010;
         end
         1: begin
            for (int i = 0; i < IMG_H*IMG_W; i++) img[i] = 16'(i);
            w[0] = 16'sh0100;
         end
         2: begin
            for (int i = 0; i < EMB_DIM; i++) b[i] = 16'(i * 256);
            for (int i = 0; i < NX; i++) pos[i] = 16'sh0080;
         end
         3, 4: begin
            for (int i = 0; i < IMG_H*IMG_W; i++) img[i] = 16'sh7FFF;
            for (int i = 0; i < PP*EMB_DIM; i++) w[i] = (mode == 3) ? 16'sh7FFF : 16'sh8001;
         end
         5, 6: begin
            img[0] = 16'sh0001;
            w[0] = (mode == 5) ? 16'sh0080 : -16'sh0080;
         end
         7, 8: begin
            for (int i = 0; i < IMG_H*IMG_W; i++) img[i] = rnd(mode == 7 ? 300 : 0);
            for (int i = 0; i < PP*EMB_DIM; i++) w[i] = rnd(mode == 7 ? 300 : 0);
            for (int i = 0; i < EMB_DIM; i++) begin
               b[i] = rnd(mode == 7 ? 2000 : 0);
               cls[i] = rnd(mode == 7 ? 2000 : 0);
            end
            for (int i = 0; i < NX; i++) pos[i] = rnd(mode == 7 ? 2000 : 0);
         end
         default: begin
            for (int i = 0; i < EMB_DIM; i++) begin cls[i] = 16'sh0100; pos[i] = 16'sh0010; end
            for (int i = 0; i < IMG_H*IMG_W; i++) img[i] = rnd(200);
            for (int i = 0; i < PP*EMB_DIM; i++) w[i] = rnd(200);
         end
      endcase
   endtask

   task automatic pulse_start(input bit track);
      @(negedge clk);
      start = 1'b1;
      if (track) start_q.push_back(cyc + 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_run(input int budget);
      int target;
      int n;
      target = runs_seen + 1;
      n = 0;
      while (runs_seen < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (runs_seen < target) begin
         failures++;
         $display("FAIL run_timeout: no done within %0d cycles (runs_seen=%0d want %0d)",
                  budget, runs_seen, target);
      end
   endtask

   task automatic check_zero(input string name);
      int nz;
      nz = 0;
      for (int i = 0; i < NX; i++) if (x_out[i] !== 16'sh0000) nz++;
      checks++;
      if (nz != 0) begin
         failures++;
         $display("FAIL %s: %0d nonzero x_out elements, required 0", name, nz);
      end
   endtask

   task automatic run_mode(input int mode);
      set_inputs(mode);
      push_expected();
      pulse_start(1'b1);
      wait_run(LAT + 50);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents done.
   always @(negedge clk) begin
      int lat;
      logic signed [15:0] ev;
      if (rst_n && (done || out_valid)) begin
         checks++;
         if (done !== out_valid) begin
            failures++;
            $display("FAIL valid_with_done: done=%b out_valid=%b, required equal", done, out_valid);
         end
      end
      if (rst_n && done) begin
         done_cnt++;
         checks++;
         if (exp_q.size() < NX || start_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_done at cycle %0d, no run pending", cyc);
         end else begin
            lat = cyc - start_q.pop_front();
            if (lat != LAT) begin
               failures++;
               $display("FAIL latency: got %0d cycles, required %0d", lat, LAT);
            end
            for (int i = 0; i < NX; i++) begin
               ev = 16'(exp_q.pop_front());
               checks++;
               if (x_out[i] !== ev) begin
                  failures++;
                  $display("FAIL x_out[%0d]: got %h, required %h", i, x_out[i], ev);
               end
            end
            runs_seen++;
         end
      end
   end

   initial begin
      int dc;
      set_inputs(0);
      repeat (3) @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: done=%b out_valid=%b, required 0 0", done, out_valid);
      end
      check_zero("reset_x_out");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("post_reset_x_out");

      for (int m = 0; m <= 9; m++) run_mode(m);
      run_mode(7);
      run_mode(8);

      // start pulse while busy must not restart the run
      set_inputs(7);
      push_expected();
      pulse_start(1'b1);
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_run(LAT + 50);

      // reset in the middle of a run: outputs cleared, no done afterwards
      set_inputs(8);
      dc = done_cnt;
      pulse_start(1'b0);
      repeat (498) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("midrun_reset_x_out");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (LAT + 100) @(negedge clk);
      checks++;
      if (done_cnt != dc) begin
         failures++;
         $display("FAIL aborted_run_done: %0d done pulses seen, required 0", done_cnt - dc);
      end
      check_zero("aborted_run_x_out");

      run_mode(8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
